// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, framebuffer defaults and write-FSM state encoding
package gpu_pkg;
  localparam int COORD_W = 8;
  localparam int COLOR_W = 24;
  localparam int FB_WIDTH_DEF = 256;
  localparam int FB_HEIGHT_DEF = 256;
  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} wr_state_e;
endpackage

// File: rtl/pixel_sync_fifo.sv
// pixel_sync_fifo: show-ahead sync FIFO (push/pop/din in; dout head, full, empty, count out); push while full is refused unless a pop frees a slot
module pixel_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: clips rasterizer pixels, buffers them, writes them over mem_req/mem_ack, reports frame_done/overflow/busy and pixel/clip counts
module pixel_fb_writer
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               shape_done,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow,
  output logic [15:0]        pix_count,
  output logic [15:0]        clip_count
);
  localparam int EW = ADDR_W + COLOR_W;
  logic in_range, push, pop, commit, fire, full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [EW-1:0] din, dout;
  wr_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLOR_W-1:0] wdata_q, wdata_d;
  logic [15:0] pix_cnt_q, pix_cnt_d, clip_cnt_q, clip_cnt_d;
  logic ovf_q, ovf_d, pend_q, pend_d, sd_q;
  assign in_range = 32'(pix_x) < FB_WIDTH && 32'(pix_y) < FB_HEIGHT;
  assign push = pix_valid && in_range;
  assign din = {ADDR_W'(pix_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(pix_x), pix_color};
  assign commit = state_q == WRITE && mem_ack;
  // IDLE pops whenever data waits; WRITE pops only on the ack that retires the current write
  assign pop = !empty && (state_q == IDLE || mem_ack);
  assign fire = pend_q && empty && state_q == IDLE;
  pixel_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_d = pop ? WRITE : (commit ? IDLE : state_q);
    {addr_d, wdata_d} = pop ? dout : {addr_q, wdata_q};
    pix_cnt_d = pix_cnt_q + 16'(commit);
    clip_cnt_d = clip_cnt_q + 16'(pix_valid && !in_range);
    ovf_d = ovf_q | (push && full && !pop);
    // a new done edge coinciding with the pulse starts a fresh pending shape
    pend_d = (shape_done && !sd_q) || (pend_q && !fire);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      pix_cnt_q <= '0;
      clip_cnt_q <= '0;
      ovf_q <= 1'b0;
      pend_q <= 1'b0;
      sd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      pix_cnt_q <= pix_cnt_d;
      clip_cnt_q <= clip_cnt_d;
      ovf_q <= ovf_d;
      pend_q <= pend_d;
      sd_q <= shape_done;
    end
  end
  assign mem_req = state_q == WRITE;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign busy = count != '0 || mem_req || pend_q;
  assign frame_done = fire;
  assign overflow = ovf_q;
  assign pix_count = pix_cnt_q;
  assign clip_count = clip_cnt_q;
endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer: randomized + directed scoreboard bench for pixel_fb_writer
module tb_pixel_fb_writer;
  localparam int W = 256;
  localparam int H = 256;
  localparam int D = 8;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic pix_valid = 0, shape_done = 0, mem_ack = 0;
  logic [7:0] pix_x = 0, pix_y = 0;
  logic [23:0] pix_color = 0;
  logic mem_req, busy, frame_done, overflow;
  logic [15:0] mem_addr, pix_count, clip_count;
  logic [23:0] mem_wdata;
  logic c_valid = 0, c_done = 0, c_ack = 0;
  logic [7:0] c_x = 0, c_y = 0;
  logic [23:0] c_color = 0;
  logic c_req, c_busy, c_fd, c_ovf;
  logic [15:0] c_addr, c_pix, c_clip;
  logic [23:0] c_wdata;

  pixel_fb_writer dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_color(pix_color), .shape_done(shape_done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .frame_done(frame_done),
    .overflow(overflow), .pix_count(pix_count), .clip_count(clip_count)
  );
  pixel_fb_writer #(.FB_WIDTH(200)) dut_clip (
    .clk(clk), .rst_n(rst_n), .pix_valid(c_valid), .pix_x(c_x), .pix_y(c_y),
    .pix_color(c_color), .shape_done(c_done), .mem_req(c_req), .mem_addr(c_addr),
    .mem_wdata(c_wdata), .mem_ack(c_ack), .busy(c_busy), .frame_done(c_fd),
    .overflow(c_ovf), .pix_count(c_pix), .clip_count(c_clip)
  );

  int errors = 0, checks = 0, fd_cnt = 0;
  typedef struct {logic [15:0] a; logic [23:0] d;} exp_t;
  exp_t sb[$];
  exp_t e_in, e_out;
  int m_cnt = 0;
  bit m_busy = 0, m_pend = 0, m_ovf = 0, m_sd = 0;
  bit m_fire, m_pop, m_inr, m_acc;
  logic [15:0] m_pix = 0, m_clip = 0;

  task automatic chk(input string n, input logic [39:0] a, input logic [39:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference model: pixels queue in order, at most D waiting plus one being written
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_busy = 0; m_pend = 0; m_ovf = 0; m_sd = 0; m_pix = 0; m_clip = 0;
      sb.delete();
    end else begin
      m_fire = m_pend && m_cnt == 0 && !m_busy;
      m_pop = m_cnt > 0 && (!m_busy || mem_ack);
      m_inr = pix_valid && int'(pix_x) < W && int'(pix_y) < H;
      m_acc = m_inr && (m_cnt < D || m_pop);
      if (pix_valid && !m_inr) m_clip++;
      if (m_inr && !m_acc) m_ovf = 1;
      if (m_acc) begin
        e_in.a = 16'(int'(pix_y) * W + int'(pix_x));
        e_in.d = pix_color;
        sb.push_back(e_in);
      end
      if (m_busy && mem_ack) m_pix++;
      m_busy = m_pop || (m_busy && !mem_ack);
      m_cnt = m_cnt - int'(m_pop) + int'(m_acc);
      m_pend = (shape_done && !m_sd) || (m_pend && !m_fire);
      m_sd = shape_done;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_req", 40'(mem_req), 40'(m_busy));
      chk("frame_done", 40'(frame_done), 40'(m_pend && m_cnt == 0 && !m_busy));
      chk("overflow", 40'(overflow), 40'(m_ovf));
      chk("busy", 40'(busy), 40'(m_cnt > 0 || m_busy || m_pend));
      chk("pix_count", 40'(pix_count), 40'(m_pix));
      chk("clip_count", 40'(clip_count), 40'(m_clip));
      if (frame_done) fd_cnt++;
      if (mem_req && mem_ack) begin
        if (sb.size() == 0) chk("write_unexpected", 40'(mem_addr), 40'hFFFFFFFFFF);
        else begin
          e_out = sb.pop_front();
          chk("mem_addr", 40'(mem_addr), 40'(e_out.a));
          chk("mem_wdata", 40'(mem_wdata), 40'(e_out.d));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] c);
    pix_valid = 1; pix_x = 8'(x); pix_y = 8'(y); pix_color = c;
    step();
    pix_valid = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin step(); n++; end
    chk("idle_timeout", 40'(busy), 40'(0));
  endtask

  initial begin
    int fd0, n;
    step(); step();
    chk("rst_req", 40'(mem_req), 0);
    chk("rst_busy", 40'(busy), 0);
    chk("rst_fd", 40'(frame_done), 0);
    chk("rst_ovf", 40'(overflow), 0);
    chk("rst_counts", 40'({pix_count, clip_count}), 0);
    chk("rst_addr_data", 40'({mem_addr, mem_wdata}), 0);
    rst_n = 1;
    step();
    // 1: single pixel, ack on second request cycle
    pix(10, 3, 24'hFF0000);
    n = 0;
    while (!mem_req && n < 10) begin step(); n++; end
    chk("t1_req_seen", 40'(mem_req), 1);
    chk("t1_addr", 40'(mem_addr), 40'd778);
    chk("t1_data", 40'(mem_wdata), 40'hFF0000);
    step();
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
    chk("t1_count", 40'(pix_count), 1);
    // 2: ten pixels with ack held high
    mem_ack = 1;
    for (int i = 0; i < 10; i++) pix(i * 7, 20 + i, 24'($urandom));
    wait_idle(40);
    chk("t2_count", 40'(pix_count), 11);
    // 3: ack held low while 12 pixels arrive, then release
    mem_ack = 0;
    for (int i = 0; i < 12; i++) pix(100 + i, 200, 24'($urandom));
    chk("t3_ovf", 40'(overflow), 1);
    mem_ack = 1;
    wait_idle(40);
    chk("t3_count", 40'(pix_count), 20);
    // 4: out-of-range pixel on the 200-wide instance
    c_valid = 1; c_x = 255; c_y = 255; c_color = 24'h123456;
    step();
    c_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_req", 40'(c_req), 0);
      step();
    end
    chk("t4_clip", 40'(c_clip), 1);
    chk("t4_pix", 40'(c_pix), 0);
    // 5: done on the same cycle as the last of three pixels
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1; pix_x = 8'(50 + i); pix_y = 8'(60); pix_color = 24'($urandom);
      shape_done = (i == 2); mem_ack = 1'($urandom);
      step();
    end
    pix_valid = 0;
    for (int i = 0; i < 30; i++) begin
      mem_ack = i > 15 ? 1'b1 : 1'($urandom);
      if (i == 5) shape_done = 0;
      step();
    end
    chk("t5_fd_once", 40'(fd_cnt - fd0), 1);
    // zero-pixel shape
    fd0 = fd_cnt;
    shape_done = 1; step(); shape_done = 0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_fd_empty_shape", 40'(fd_cnt - fd0), 1);
    // 6: async reset during WRITE with a full FIFO
    mem_ack = 0;
    for (int i = 0; i < 10; i++) pix(i, i, 24'($urandom));
    rst_n = 0;
    #1;
    chk("t6_req_drop", 40'(mem_req), 0);
    chk("t6_counts", 40'({pix_count, clip_count}), 0);
    chk("t6_ovf", 40'(overflow), 0);
    chk("t6_busy", 40'(busy), 0);
    step();
    rst_n = 1;
    step();
    mem_ack = 1;
    pix(5, 7, 24'hABCDEF);
    wait_idle(20);
    chk("t6_after", 40'(pix_count), 1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      pix_valid = $urandom_range(0, 2) != 0;
      pix_x = 8'($urandom); pix_y = 8'($urandom); pix_color = 24'($urandom);
      mem_ack = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) shape_done = ~shape_done;
      step();
    end
    pix_valid = 0; mem_ack = 1; shape_done = 0;
    wait_idle(100);
    chk("sb_drained", 40'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
